// File: rtl/latch_bank_sequencer_if.sv
// Requester-side and latch-bank-side signals of the latch bank write sequencer.
// The master modport is the requester/bench side; the slave modport is the sequencer.
interface latch_bank_sequencer_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 freeze;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        latch_d;
    logic [(1<<AW)-1:0]   latch_en;
    logic                 busy;

    modport master (
        output req, req_addr, req_data, freeze,
        input  ack, latch_d, latch_en, busy
    );

    modport slave (
        input  req, req_addr, req_data, freeze,
        output ack, latch_d, latch_en, busy
    );
endinterface

// File: rtl/latch_bank_sequencer.sv
// Round-robin write controller for a bank of level-sensitive latch words.
// Sequences setup / gate-open / hold so each latch sees a stable D across its open window.
module latch_bank_sequencer #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input logic                   input_clock1_clk,
    input logic                   input_reset1_rst_n,
    latch_bank_sequencer_if.slave bus
);
    localparam int NW   = 1 << AW;
    localparam int MAXC = (SETUP_CYC > GATE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((GATE_CYC  > HOLD_CYC) ? GATE_CYC  : HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   rr, rr_nxt;
    logic [IW-1:0]   winner, winner_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic [DW-1:0]   d_q, d_nxt;
    logic [NW-1:0]   en_q, en_nxt;
    logic [NREQ-1:0] ack_q, ack_nxt;
    logic            busy_q, busy_nxt;

    logic            grant_ok;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;

    // Round-robin search starting at rr; the first requester found wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_ok = 1'b0;
        pick     = '0;
        idx      = rr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_ok && bus.req[idx]) begin
                grant_ok = 1'b1;
                pick     = idx;
            end
            idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_nxt     = rr;
        winner_nxt = winner;
        addr_nxt   = addr;
        d_nxt      = d_q;
        unique case (state)
            IDLE: begin
                if (!bus.freeze && grant_ok) begin
                    state_nxt  = SETUP;
                    cnt_nxt    = '0;
                    winner_nxt = pick;
                    addr_nxt   = bus.req_addr[pick*AW +: AW];
                    d_nxt      = bus.req_data[pick*DW +: DW];
                end
            end
            SETUP: begin
                if (cnt == CW'(SETUP_CYC - 1)) begin
                    state_nxt = GATE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GATE: begin
                if (cnt == CW'(GATE_CYC - 1)) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(HOLD_CYC - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rr_nxt    = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops themselves drive the pins.
        en_nxt = '0;
        if (state_nxt == GATE) en_nxt[addr_nxt] = 1'b1;
        ack_nxt = '0;
        if (state_nxt == HOLD && cnt_nxt == CW'(HOLD_CYC - 1)) ack_nxt[winner_nxt] = 1'b1;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge input_clock1_clk or negedge input_reset1_rst_n) begin
        if (!input_reset1_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rr     <= '0;
            winner <= '0;
            addr   <= '0;
            d_q    <= '0;
            en_q   <= '0;
            ack_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rr     <= rr_nxt;
            winner <= winner_nxt;
            addr   <= addr_nxt;
            d_q    <= d_nxt;
            en_q   <= en_nxt;
            ack_q  <= ack_nxt;
            busy_q <= busy_nxt;
        end
    end

    assign bus.latch_d  = d_q;
    assign bus.latch_en = en_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Bench for latch_bank_sequencer: two instances (1/1/1 and 2/3/2 phase lengths) share stimulus
// and are compared every cycle against a transaction-level model built from phase offsets.
module tb_latch_bank_sequencer;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 2;
    localparam int NW   = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               freeze;

    latch_bank_sequencer_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus0 ();
    latch_bank_sequencer_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus1 ();

    assign bus0.req = req;  assign bus0.req_addr = req_addr;
    assign bus0.req_data = req_data;  assign bus0.freeze = freeze;
    assign bus1.req = req;  assign bus1.req_addr = req_addr;
    assign bus1.req_data = req_data;  assign bus1.freeze = freeze;

    latch_bank_sequencer #(.NREQ(NREQ), .DW(DW), .AW(AW),
        .SETUP_CYC(1), .GATE_CYC(1), .HOLD_CYC(1)) u_dut0 (
        .input_clock1_clk(clk), .input_reset1_rst_n(rst_n), .bus(bus0));
    latch_bank_sequencer #(.NREQ(NREQ), .DW(DW), .AW(AW),
        .SETUP_CYC(2), .GATE_CYC(3), .HOLD_CYC(2)) u_dut1 (
        .input_clock1_clk(clk), .input_reset1_rst_n(rst_n), .bus(bus1));

    // Reference model: one pending/active transfer per instance, located by its capture cycle.
    int            s_cyc [2] = '{1, 2};
    int            g_cyc [2] = '{1, 3};
    int            h_cyc [2] = '{1, 2};
    bit            m_act [2];
    int            m_start [2];
    int            m_win [2];
    int            m_addr [2];
    logic [DW-1:0] m_d [2];
    int            m_rr [2];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int ack_order0 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 1'b0; m_start[k] = 0; m_win[k] = 0; m_addr[k] = 0;
            m_d[k] = '0; m_rr[k] = 0;
        end
    endtask

    function automatic bit model_idle(input int k);
        return !m_act[k] || (cyc - m_start[k] > s_cyc[k] + g_cyc[k] + h_cyc[k]);
    endfunction

    // Decide a grant for the current cycle from the inputs that will be sampled at the next edge.
    task automatic model_eval(input int k);
        int w;
        int i;
        if (!rst_n) return;
        if (model_idle(k) && !freeze && req != '0) begin
            w = -1;
            for (int j = 0; j < NREQ; j++) begin
                i = (m_rr[k] + j) % NREQ;
                if (w < 0 && req[i]) w = i;
            end
            m_act[k]   = 1'b1;
            m_start[k] = cyc;
            m_win[k]   = w;
            m_addr[k]  = int'(req_addr[w*AW +: AW]);
            m_d[k]     = req_data[w*DW +: DW];
            m_rr[k]    = (w + 1) % NREQ;
        end
    endtask

    task automatic check_dut(input int k, input logic [NREQ-1:0] ack, input logic [DW-1:0] d,
                             input logic [NW-1:0] en, input logic busy);
        int p, s, g, t;
        logic [NREQ-1:0] e_ack;
        logic [NW-1:0]   e_en;
        logic            e_busy;
        s = s_cyc[k]; g = g_cyc[k]; t = s + g + h_cyc[k];
        p = cyc - m_start[k];
        e_ack = '0; e_en = '0; e_busy = 1'b0;
        if (m_act[k] && p >= 1 && p <= t) begin
            e_busy = 1'b1;
            if (p > s && p <= s + g) e_en[m_addr[k]] = 1'b1;
            if (p == t) e_ack[m_win[k]] = 1'b1;
        end
        check($sformatf("dut%0d_busy", k), 32'(busy), 32'(e_busy));
        check($sformatf("dut%0d_latch_d", k), 32'(d), 32'(m_d[k]));
        check($sformatf("dut%0d_latch_en", k), 32'(en), 32'(e_en));
        check($sformatf("dut%0d_ack", k), 32'(ack), 32'(e_ack));
        check($sformatf("dut%0d_en_onehot0", k), 32'($onehot0(en)), 32'd1);
    endtask

    task automatic check_both();
        check_dut(0, bus0.ack, bus0.latch_d, bus0.latch_en, bus0.busy);
        check_dut(1, bus1.ack, bus1.latch_d, bus1.latch_en, bus1.busy);
    endtask

    // One clock: model decides on current inputs, DUTs take the edge, outputs checked mid-cycle.
    task automatic cycle();
        model_eval(0);
        model_eval(1);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_both();
        for (int i = 0; i < NREQ; i++) if (bus0.ack[i]) ack_order0.push_back(i);
    endtask

    task automatic drain();
        req = '0;
        for (int n = 0; n < 40 && !(model_idle(0) && model_idle(1)); n++) cycle();
        cycle();
        check("drain_busy0", 32'(bus0.busy), 32'd0);
        check("drain_busy1", 32'(bus1.busy), 32'd0);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        req = '0; req_addr = '0; req_data = '0; freeze = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_both();
        rst_n = 1'b1;

        // Single write: requester 0, addr 2, data A5; its data input is zeroed during GATE.
        req = 4'b0001;
        req_addr[0 +: AW] = 2'd2;
        req_data[0 +: DW] = 8'hA5;
        cycle();
        check("single_latch_d", 32'(bus0.latch_d), 32'hA5);
        cycle();
        check("single_gate_en", 32'(bus0.latch_en), 32'b0100);
        req_data[0 +: DW] = 8'h00;
        cycle();
        check("single_ack", 32'(bus0.ack), 32'b0001);
        req = '0;
        drain();

        // Freeze raised during GATE of a transfer to addr 1 from requester 2.
        req = 4'b0100;
        req_addr[2*AW +: AW] = 2'd1;
        req_data[2*DW +: DW] = 8'h5A;
        cycle();
        cycle();
        freeze = 1'b1;
        req = 4'b0101;
        repeat (12) cycle();
        check("freeze_hold_busy0", 32'(bus0.busy), 32'd0);
        freeze = 1'b0;
        cycle();
        check("unfreeze_grant", 32'(bus0.busy), 32'd1);
        drain();

        // Reset in GATE: rr is nonzero beforehand, must be 0 after release.
        req = 4'b0010;
        cycle();
        cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_both();
        @(negedge clk);
        check_both();
        req = 4'hF;
        req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        rst_n = 1'b1;
        ack_order0.delete();

        // Full contention with distinct addresses.
        repeat (22) cycle();
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_order_%0d", i),
                  (ack_order0.size() > i) ? 32'(ack_order0[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        drain();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) req = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) req_addr = (NREQ*AW)'($urandom);
            req_data = {$urandom};
            freeze = ($urandom_range(0, 7) == 0);
            cycle();
        end
        freeze = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
